// File: rtl/matrix_cfg_loader_if.sv
// Configuration-stream interface for matrix_cfg_loader.
// The upstream agent (master) drives the serial stream and the clear.
// The loader (slave) drives the four packed select buses and the status strobes.
//   cfg_din/cfg_valid : serial config bit, and the strobe that says when it is sampled
//   cfg_clr           : synchronous clear of the active config; aborts any load
//   cfg_top/bottom    : N_TB select words each, word i at [SEL_W*i +: SEL_W]
//   cfg_left/right    : N_LR select words each, same packing
//   cfg_busy          : a frame is being loaded or checked
//   cfg_done/cfg_err  : one-cycle commit / reject pulses
interface matrix_cfg_loader_if #(
    parameter int N_TB  = 5,
    parameter int N_LR  = 4,
    parameter int SEL_W = 6
);
    logic                    cfg_din;
    logic                    cfg_valid;
    logic                    cfg_clr;
    logic [N_TB*SEL_W-1:0]   cfg_top;
    logic [N_TB*SEL_W-1:0]   cfg_bottom;
    logic [N_LR*SEL_W-1:0]   cfg_left;
    logic [N_LR*SEL_W-1:0]   cfg_right;
    logic                    cfg_busy;
    logic                    cfg_done;
    logic                    cfg_err;

    modport master (
        output cfg_din, cfg_valid, cfg_clr,
        input  cfg_top, cfg_bottom, cfg_left, cfg_right,
        input  cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_din, cfg_valid, cfg_clr,
        output cfg_top, cfg_bottom, cfg_left, cfg_right,
        output cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/matrix_cfg_loader.sv
// Serial configuration loader for the switch-matrix tile.
// It hunts SYNC on the 1-bit stream, then shifts one frame into a shadow register.
// The frame is 18 select words followed by a checksum.
// The frame is checked for checksum and word legality, and then committed atomically
// to the active select buses.
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   cfg   : matrix_cfg_loader_if.slave (stream in, select buses and status out)
module matrix_cfg_loader #(
    parameter int         N_TB  = 5,
    parameter int         N_LR  = 4,
    parameter int         SEL_W = 6,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_cfg_loader_if.slave cfg
);
    localparam int N_WORDS    = 2*N_TB + 2*N_LR;
    localparam int FRAME_BITS = N_WORDS*SEL_W;
    localparam int PAY_BITS   = FRAME_BITS + SEL_W;
    localparam int CNT_W      = $clog2(PAY_BITS);
    localparam int IDX_W      = SEL_W - 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_sync;
    logic [CNT_W-1:0]        r_cnt;
    logic [PAY_BITS-1:0]     r_shadow;
    logic [FRAME_BITS-1:0]   r_act;     // active config, word k at [k*SEL_W +: SEL_W]
    logic                    r_done;
    logic                    r_err;

    logic [7:0]              w_sync_nxt;
    logic                    w_sync_hit;
    logic                    w_last_bit;
    logic                    w_commit;
    logic                    w_reject;
    logic                    w_frame_ok;
    logic [SEL_W-1:0]        w_word [N_WORDS];
    logic [SEL_W-1:0]        w_xor;
    logic [N_WORDS-1:0]      w_illegal;

    assign w_sync_nxt = {r_sync[6:0], cfg.cfg_din};
    assign w_sync_hit = cfg.cfg_valid && (w_sync_nxt == SYNC);
    assign w_last_bit = cfg.cfg_valid && (r_cnt == CNT_W'(PAY_BITS-1));

    // Payload arrives MSB first, so the first word ends up at the top of the shadow.
    for (genvar k = 0; k < N_WORDS; k++) begin : g_word
        localparam int OWN_SIDE = (k < N_TB)          ? 1 :
                                  (k < 2*N_TB)        ? 3 :
                                  (k < 2*N_TB + N_LR) ? 4 : 2;
        localparam int OWN_IDX  = (k < N_TB)          ? k :
                                  (k < 2*N_TB)        ? k - N_TB :
                                  (k < 2*N_TB + N_LR) ? k - 2*N_TB : k - 2*N_TB - N_LR;

        logic [2:0]       w_side;
        logic [IDX_W-1:0] w_idx;

        assign w_word[k] = r_shadow[PAY_BITS-1-k*SEL_W -: SEL_W];
        assign w_side    = w_word[k][2:0];
        assign w_idx     = w_word[k][SEL_W-1:3];

        // Side 0 (open) is legal with any index.
        // A word may not name its own wire.
        assign w_illegal[k] = (w_side > 3'd4) ||
                              (((w_side == 3'd1) || (w_side == 3'd3)) && (w_idx > IDX_W'(N_TB-1))) ||
                              (((w_side == 3'd2) || (w_side == 3'd4)) && (w_idx > IDX_W'(N_LR-1))) ||
                              ((w_side == 3'(OWN_SIDE)) && (w_idx == IDX_W'(OWN_IDX)));
    end

    always_comb begin
        w_xor = '0;
        for (int k = 0; k < N_WORDS; k++) w_xor = w_xor ^ w_word[k];
    end

    assign w_frame_ok = (w_xor == r_shadow[SEL_W-1:0]) && !(|w_illegal);

    // Next-state and pulse decode; cfg_clr overrides everything, including the CHECK exit.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        if (cfg.cfg_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_sync_hit) w_state_nxt = S_LOAD;
                S_LOAD:  if (w_last_bit) w_state_nxt = S_CHECK;
                S_CHECK: begin
                    w_state_nxt = S_IDLE;
                    w_commit    = w_frame_ok;
                    w_reject    = !w_frame_ok;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_act    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_err  <= w_reject;
            if (cfg.cfg_clr) begin
                r_sync   <= '0;
                r_cnt    <= '0;
                r_shadow <= '0;
                r_act    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        // Zeroing on a hit leaves the register clean for the next return to IDLE.
                        if (cfg.cfg_valid) r_sync <= w_sync_hit ? 8'h00 : w_sync_nxt;
                    end
                    S_LOAD: begin
                        if (cfg.cfg_valid) begin
                            r_shadow <= {r_shadow[PAY_BITS-2:0], cfg.cfg_din};
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_CHECK: begin
                        r_sync <= '0;
                        r_cnt  <= '0;
                        if (w_commit) begin
                            for (int k = 0; k < N_WORDS; k++)
                                r_act[k*SEL_W +: SEL_W] <= w_word[k];
                        end
                    end
                    default: begin
                        r_sync <= '0;
                        r_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign cfg.cfg_top    = r_act[N_TB*SEL_W-1:0];
    assign cfg.cfg_bottom = r_act[2*N_TB*SEL_W-1:N_TB*SEL_W];
    assign cfg.cfg_left   = r_act[(2*N_TB+N_LR)*SEL_W-1:2*N_TB*SEL_W];
    assign cfg.cfg_right  = r_act[FRAME_BITS-1:(2*N_TB+N_LR)*SEL_W];
    assign cfg.cfg_busy   = (r_state != S_IDLE);
    assign cfg.cfg_done   = r_done;
    assign cfg.cfg_err    = r_err;
endmodule

// File: tb/tb_matrix_cfg_loader.sv
module tb_matrix_cfg_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matrix_cfg_loader_if bus ();
    matrix_cfg_loader dut (.clk(clk), .rst_n(rst_n), .cfg(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_err = 0, n_busy = 0, n_both = 0;

    logic [5:0] fr_w  [18];     // frame being sent
    logic [5:0] fr_chk;
    logic [5:0] exp_w [18];     // reference model of the active config
    logic [7:0] win;            // bench view of the last 8 stream bits seen in IDLE

    always @(negedge clk) begin
        if (bus.cfg_done) n_done++;
        if (bus.cfg_err)  n_err++;
        if (bus.cfg_busy) n_busy++;
        if (bus.cfg_done && bus.cfg_err) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    function automatic bit mdl_legal(input int k, input logic [5:0] w);
        int side, idx, own_side, own_idx;
        side = int'(w[2:0]);
        idx  = int'(w[5:3]);
        if (k < 5)       begin own_side = 1; own_idx = k;      end
        else if (k < 10) begin own_side = 3; own_idx = k - 5;  end
        else if (k < 14) begin own_side = 4; own_idx = k - 10; end
        else             begin own_side = 2; own_idx = k - 14; end
        if (side > 4) return 0;
        if (side == 0) return 1;
        if ((side == 1 || side == 3) && idx > 4) return 0;
        if ((side == 2 || side == 4) && idx > 3) return 0;
        if (side == own_side && idx == own_idx) return 0;
        return 1;
    endfunction

    function automatic logic [5:0] mdl_xor();
        logic [5:0] x = 6'h0;
        for (int k = 0; k < 18; k++) x ^= fr_w[k];
        return x;
    endfunction

    function automatic bit mdl_ok();
        if (mdl_xor() != fr_chk) return 0;
        for (int k = 0; k < 18; k++) if (!mdl_legal(k, fr_w[k])) return 0;
        return 1;
    endfunction

    function automatic logic [29:0] exp_bus(input int first, input int n);
        logic [29:0] v = '0;
        for (int i = 0; i < n; i++) v[6*i +: 6] = exp_w[first+i];
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.cfg_din   = b;
        bus.cfg_valid = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.cfg_din   = 1'($urandom);
    endtask

    // Random bits that never complete SYNC; optional zero pad so no tail of the junk
    // can combine with the start of a following SYNC.
    task automatic send_junk(input int n, input bit pad);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({win[6:0], b} == 8'hA5) b = ~b;
            win = {win[6:0], b};
            send_bit(b);
        end
        if (pad) for (int i = 0; i < 8; i++) begin
            win = {win[6:0], 1'b0};
            send_bit(1'b0);
        end
    endtask

    task automatic send_sync();
        logic [7:0] s = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
        win = 8'h00;
    endtask

    // Sends payload bits; stops early after stop_at bits when stop_at >= 0.
    task automatic send_payload(input bit stall, input int stop_at);
        logic q[$];
        for (int k = 0; k < 18; k++) for (int b = 5; b >= 0; b--) q.push_back(fr_w[k][b]);
        for (int b = 5; b >= 0; b--) q.push_back(fr_chk[b]);
        for (int i = 0; i < q.size(); i++) begin
            if (i == stop_at) return;
            if (stall && i[0]) idle_cycle();
            if (stall && i == 50) repeat (20) idle_cycle();
            send_bit(q[i]);
        end
    endtask

    task automatic check_buses(input string tag);
        chk({tag, ".top"},    64'(bus.cfg_top),    64'(exp_bus(0, 5)));
        chk({tag, ".bottom"}, 64'(bus.cfg_bottom), 64'(exp_bus(5, 5)));
        chk({tag, ".left"},   64'(bus.cfg_left),   64'(exp_bus(10, 4)));
        chk({tag, ".right"},  64'(bus.cfg_right),  64'(exp_bus(14, 4)));
    endtask

    // Called right after the last payload bit is driven.
    task automatic finish_check(input string tag, input bit clr_in_check);
        bit ok = mdl_ok();
        @(negedge clk);                 // edge that sampled the last bit has passed
        bus.cfg_valid = 1'b0;
        chk({tag, ".busy_chk"}, 64'(bus.cfg_busy), 64'd1);
        chk({tag, ".done_early"}, 64'(bus.cfg_done), 64'd0);
        check_buses({tag, ".hold"});
        if (clr_in_check) bus.cfg_clr = 1'b1;
        @(negedge clk);                 // second edge: commit / reject / clear
        bus.cfg_clr = 1'b0;
        if (clr_in_check) begin
            for (int k = 0; k < 18; k++) exp_w[k] = 6'h0;
            chk({tag, ".done"}, 64'(bus.cfg_done), 64'd0);
            chk({tag, ".err"},  64'(bus.cfg_err),  64'd0);
        end else begin
            if (ok) for (int k = 0; k < 18; k++) exp_w[k] = fr_w[k];
            chk({tag, ".done"}, 64'(bus.cfg_done), 64'(ok));
            chk({tag, ".err"},  64'(bus.cfg_err),  64'(!ok));
        end
        chk({tag, ".busy_end"}, 64'(bus.cfg_busy), 64'd0);
        check_buses(tag);
        @(negedge clk);
        chk({tag, ".pulse1"}, 64'(bus.cfg_done | bus.cfg_err), 64'd0);
    endtask

    task automatic run_frame(input string tag, input bit stall, input bit clr_in_check);
        send_junk($urandom_range(0, 6), 1'b1);
        send_sync();
        send_payload(stall, -1);
        finish_check(tag, clr_in_check);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 18; k++) fr_w[k] = 6'h0;
        fr_chk = 6'h0;
    endtask

    task automatic load_ref_frame();
        clear_frame();
        fr_w[0]  = 6'h0A;   // top0  <- right[1]
        fr_w[15] = 6'h01;   // right1 <- top[0]
        fr_chk   = 6'h0B;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.cfg_clr   = 1'b1;
        @(negedge clk);
        bus.cfg_clr   = 1'b0;
        for (int k = 0; k < 18; k++) exp_w[k] = 6'h0;
        win = 8'h00;
    endtask

    initial begin
        int d0, e0, b0, side, idx;
        rst_n = 1'b0;
        bus.cfg_din = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_clr = 1'b0;
        win = 8'h00;
        for (int k = 0; k < 18; k++) exp_w[k] = 6'h0;
        clear_frame();
        repeat (3) @(negedge clk);
        check_buses("rst");
        chk("rst.busy", 64'(bus.cfg_busy), 64'd0);
        chk("rst.done", 64'(bus.cfg_done), 64'd0);
        chk("rst.err",  64'(bus.cfg_err),  64'd0);
        rst_n = 1'b1;

        // Directed reference frame, junk 110 in front.
        load_ref_frame();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_sync();
        send_payload(1'b0, -1);
        finish_check("vf", 1'b0);
        chk("vf.top0",   64'(bus.cfg_top[5:0]),   64'h0A);
        chk("vf.right1", 64'(bus.cfg_right[11:6]), 64'h01);

        // Bad checksum: buses keep the committed frame.
        load_ref_frame();
        fr_chk = 6'h0A;
        run_frame("csum", 1'b0, 1'b0);

        // Illegal words, each with a correct checksum.
        clear_frame(); fr_w[0]  = 6'h01; fr_chk = mdl_xor(); run_frame("self", 1'b0, 1'b0);
        clear_frame(); fr_w[12] = 6'h2A; fr_chk = mdl_xor(); run_frame("ridx", 1'b0, 1'b0);
        clear_frame(); fr_w[8]  = 6'h07; fr_chk = mdl_xor(); run_frame("side7", 1'b0, 1'b0);

        // Clear after commit.
        pulse_clr();
        check_buses("clr");
        chk("clr.pulse", 64'(bus.cfg_done | bus.cfg_err), 64'd0);

        // Stalled frame commits identically.
        load_ref_frame();
        run_frame("stall", 1'b1, 1'b0);

        // Clear at payload bit 60, then a full frame.
        load_ref_frame();
        fr_w[3] = 6'h22; fr_chk = mdl_xor();
        send_junk(2, 1'b1);
        send_sync();
        send_payload(1'b0, 60);
        d0 = n_done; e0 = n_err;
        pulse_clr();
        chk("clr60.busy", 64'(bus.cfg_busy), 64'd0);
        check_buses("clr60");
        repeat (3) idle_cycle();
        chk("clr60.nopulse", 64'((n_done - d0) + (n_err - e0)), 64'd0);
        run_frame("clr60.next", 1'b0, 1'b0);

        // Clear coincident with the CHECK exit of a good frame.
        load_ref_frame();
        run_frame("clrchk", 1'b0, 1'b1);

        // Reset in the middle of a load.
        load_ref_frame();
        run_frame("pre_rst", 1'b0, 1'b0);
        send_sync();
        send_payload(1'b0, 30);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 18; k++) exp_w[k] = 6'h0;
        check_buses("mrst");
        chk("mrst.busy", 64'(bus.cfg_busy), 64'd0);
        chk("mrst.pulse", 64'(bus.cfg_done | bus.cfg_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        win = 8'h00;
        repeat (2) idle_cycle();
        d0 = n_done; e0 = n_err; b0 = n_busy;
        send_junk(114, 1'b0);
        repeat (3) idle_cycle();
        chk("nosync.busy",  64'(n_busy - b0), 64'd0);
        chk("nosync.pulse", 64'((n_done - d0) + (n_err - e0)), 64'd0);

        // Random frames against the model.
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 18; k++) begin
                if ($urandom_range(0, 39) == 0) fr_w[k] = 6'($urandom);
                else begin
                    side = $urandom_range(0, 4);
                    if (side == 0)                  idx = $urandom_range(0, 7);
                    else if (side == 1 || side == 3) idx = $urandom_range(0, 4);
                    else                            idx = $urandom_range(0, 3);
                    fr_w[k] = {3'(idx), 3'(side)};
                end
            end
            fr_chk = mdl_xor();
            if ($urandom_range(0, 6) == 0) fr_chk ^= 6'($urandom_range(1, 63));
            run_frame($sformatf("rnd%0d", f), 1'($urandom_range(0, 3) == 0), 1'b0);
        end

        chk("done_err_excl", 64'(n_both), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
